// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side drain controller and its skid buffer.
package fifo_pkg;

    localparam int FIFO_WIDTH = 16;
    localparam int FIFO_DEPTH = 16;
    localparam int SKID_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } rd_state_e;

    // Skid occupancy one edge ahead: current entries plus the word landing now, minus the one leaving.
    function automatic logic [2:0] skid_fill(input logic [1:0] occ,
                                             input logic       inflight,
                                             input logic       pop);
        return {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry ordered buffer between the FIFO read data and the downstream stream; head is dout.
module fifo_rd_skid #(
    parameter int WIDTH = fifo_pkg::FIFO_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       occ
);
    import fifo_pkg::*;

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       occ_q, occ_d;
    logic             pop_ok;
    logic             push_ok;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        occ_d   = occ_q;
        pop_ok  = pop && (occ_q != 2'd0);
        // A push into a full buffer is only accepted when the head leaves in the same cycle.
        push_ok = push && ((occ_q != 2'(SKID_DEPTH)) || pop_ok);

        case ({push_ok, pop_ok})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_d = din;
                end else begin
                    tail_d = din;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    head_d = din;
                end else begin
                    head_d = tail_q;
                    tail_d = din;
                end
            end
            default: begin
                occ_d = occ_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign dout = head_q;
    assign occ  = occ_q;

endmodule

// File: rtl/fifo_rd_drain.sv
// Read-side FIFO controller: issues reads, captures the registered read data into a skid
// buffer and presents it as a valid/ready stream, with a delivered-word counter and a sticky underflow flag.
module fifo_rd_drain #(
    parameter int FIFO_WIDTH = fifo_pkg::FIFO_WIDTH,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    output logic                  fifo_rd_en,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  busy,
    output logic [CNT_W-1:0]      rd_count,
    output logic                  err_underflow,
    input  logic                  clr_err
);
    import fifo_pkg::*;

    rd_state_e        state_q, state_d;
    logic             inflight_q;
    logic [CNT_W-1:0] rd_count_q, rd_count_d;
    logic             err_q, err_d;
    logic [1:0]       occ;
    logic             pop;
    logic             rd_en;
    logic             err_set;

    fifo_rd_skid #(
        .WIDTH (FIFO_WIDTH)
    ) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight_q),
        .pop   (pop),
        .din   (fifo_data_out),
        .dout  (m_data),
        .occ   (occ)
    );

    assign m_valid = (occ != 2'd0);
    assign pop     = m_valid && m_ready;

    // Reserve a skid slot for every word already requested so the buffer can never overflow.
    assign rd_en = (state_q == ACTIVE) && en && !fifo_empty
                   && (skid_fill(occ, inflight_q, pop) < 3'(SKID_DEPTH));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (!en) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (en) begin
                    state_d = ACTIVE;
                end else if (!inflight_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        rd_count_d = rd_count_q;
        if (pop) begin
            rd_count_d = rd_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Set has priority over clear so an underflow in the clearing cycle is not lost.
    assign err_set = fifo_underflow || (rd_en && fifo_empty);

    always_comb begin
        err_d = err_q;
        if (err_set) begin
            err_d = 1'b1;
        end else if (clr_err) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            inflight_q <= 1'b0;
            rd_count_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= rd_en;
            rd_count_q <= rd_count_d;
            err_q      <= err_d;
        end
    end

    assign fifo_rd_en    = rd_en;
    assign busy          = (state_q != IDLE) || (occ != 2'd0);
    assign rd_count      = rd_count_q;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Randomized self-checking bench for fifo_rd_drain against a queue-based reference model and FIFO model.
module tb_fifo_rd_drain;

    localparam int W = 16;
    localparam int C = 16;
    localparam int DEPTH = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         fifo_rd_en;
    logic [W-1:0] fifo_data_out;
    logic         fifo_empty;
    logic         fifo_underflow;
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_ready;
    logic         busy;
    logic [C-1:0] rd_count;
    logic         err_underflow;
    logic         clr_err;

    fifo_rd_drain #(.FIFO_WIDTH(W), .CNT_W(C)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .fifo_rd_en     (fifo_rd_en),
        .fifo_data_out  (fifo_data_out),
        .fifo_empty     (fifo_empty),
        .fifo_underflow (fifo_underflow),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .busy           (busy),
        .rd_count       (rd_count),
        .err_underflow  (err_underflow),
        .clr_err        (clr_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: mode 0 idle, 1 reading, 2 finishing the outstanding read.
    int           mode;
    logic         infl;
    logic [W-1:0] sk[$];
    logic         exp_err;
    logic [C-1:0] exp_cnt;
    logic [W-1:0] fq[$];
    logic [W-1:0] written[$];
    int           out_idx;
    int           wr_left;
    int           wr_pct;
    int           rd_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mode    = 0;
        infl    = 1'b0;
        sk.delete();
        exp_err = 1'b0;
        exp_cnt = '0;
        fq.delete();
        written.delete();
        out_idx = 0;
        wr_left = 0;
        fifo_data_out = '0;
        fifo_empty    = 1'b1;
    endtask

    task automatic preload(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            fq.push_back(W'(base + i));
            written.push_back(W'(base + i));
        end
        fifo_empty = (fq.size() == 0);
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic cycle();
        logic         exp_mv, exp_rd, pop, rd_dut, set;
        logic [W-1:0] cap;
        int           fill;
        #1;
        exp_mv = (sk.size() != 0);
        pop    = exp_mv && m_ready;
        fill   = sk.size() + int'(infl) - int'(pop);
        exp_rd = (mode == 1) && en && !fifo_empty && (fill < 2);
        chk("rd_en", fifo_rd_en, exp_rd);
        chk("m_valid", m_valid, exp_mv);
        if (exp_mv) chk("m_data", m_data, sk[0]);
        chk("busy", busy, (mode != 0) || (sk.size() != 0));
        chk("rd_count", rd_count, exp_cnt);
        chk("err", err_underflow, exp_err);
        if (pop) begin
            if (out_idx < written.size()) chk("order", m_data, written[out_idx]);
            else chk("extra_word", 1'b1, 1'b0);
            out_idx++;
        end
        rd_dut = fifo_rd_en;
        if (rd_dut) rd_seen++;
        cap = fifo_data_out;
        set = fifo_underflow || (exp_rd && fifo_empty);
        @(posedge clk);
        #1;
        if (pop) begin
            void'(sk.pop_front());
            exp_cnt = exp_cnt + 1'b1;
        end
        if (infl) sk.push_back(cap);
        case (mode)
            0: if (en) mode = 1;
            1: if (!en) mode = 2;
            default: if (en) mode = 1; else if (!infl) mode = 0;
        endcase
        infl = exp_rd;
        if (set) exp_err = 1'b1;
        else if (clr_err) exp_err = 1'b0;
        if (rd_dut && fq.size() > 0) fifo_data_out = fq.pop_front();
        if (wr_left > 0 && fq.size() < DEPTH && $urandom_range(99) < wr_pct) begin
            logic [W-1:0] v;
            v = W'($urandom);
            fq.push_back(v);
            written.push_back(v);
            wr_left--;
        end
        fifo_empty = (fq.size() == 0);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int budget;
        rst_n = 1'b0;
        en = 1'b0;
        m_ready = 1'b0;
        clr_err = 1'b0;
        fifo_underflow = 1'b0;
        wr_pct = 0;
        rd_seen = 0;
        model_reset();
        #1;
        chk("rst_rd_en", fifo_rd_en, 1'b0);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_data", m_data, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rd_count", rd_count, '0);
        chk("rst_err", err_underflow, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run(2);

        // Streaming 8 preloaded words with the consumer always ready.
        preload(8, 1);
        en = 1'b1;
        m_ready = 1'b1;
        rd_seen = 0;
        run(14);
        chk("stream_reads", rd_seen, 8);
        chk("stream_count", rd_count, 8);
        en = 1'b0;
        run(4);

        // Backpressure: only two words may be fetched while the consumer stalls.
        preload(8, 16'h0001);
        en = 1'b1;
        m_ready = 1'b0;
        rd_seen = 0;
        run(10);
        chk("bp_reads", rd_seen, 2);
        chk("bp_head", m_data, 16'h0001);
        m_ready = 1'b1;
        run(14);
        chk("bp_all_out", out_idx, written.size());
        en = 1'b0;
        run(4);

        // Drop en the cycle after the first read; the in-flight word must still come out.
        preload(3, 16'h0100);
        en = 1'b1;
        rd_seen = 0;
        budget = 0;
        while (rd_seen == 0 && budget < 20) begin
            cycle();
            budget++;
        end
        chk("drain_first_rd", rd_seen, 1);
        en = 1'b0;
        run(6);
        chk("drain_reads", rd_seen, 1);
        chk("drain_busy", busy, 1'b0);
        chk("drain_out", out_idx, written.size() - 2);

        // Sticky underflow flag with clear and set/clear collision.
        fifo_underflow = 1'b1;
        cycle();
        fifo_underflow = 1'b0;
        run(2);
        chk("uf_sticky", err_underflow, 1'b1);
        clr_err = 1'b1;
        cycle();
        clr_err = 1'b0;
        chk("uf_cleared", err_underflow, 1'b0);
        fifo_underflow = 1'b1;
        cycle();
        fifo_underflow = 1'b0;
        clr_err = 1'b1;
        fifo_underflow = 1'b1;
        cycle();
        clr_err = 1'b0;
        fifo_underflow = 1'b0;
        chk("uf_set_wins", err_underflow, 1'b1);
        clr_err = 1'b1;
        cycle();
        clr_err = 1'b0;

        // Random producer and 50% consumer readiness over 1000 words.
        en = 1'b1;
        wr_pct = 70;
        wr_left = 1000;
        budget = 0;
        while ((wr_left > 0 || out_idx < written.size()) && budget < 20000) begin
            m_ready = ($urandom_range(1) == 1);
            cycle();
            budget++;
        end
        if (budget >= 20000) chk("rand_timeout", 1'b1, 1'b0);
        chk("rand_all_out", out_idx, written.size());
        chk("rand_err", err_underflow, 1'b0);

        // Asynchronous reset while the skid holds two words.
        m_ready = 1'b0;
        preload(4, 16'h0A00);
        run(6);
        chk("pre_rst_occ2", m_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rd_en", fifo_rd_en, 1'b0);
        chk("arst_m_valid", m_valid, 1'b0);
        chk("arst_m_data", m_data, '0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_rd_count", rd_count, '0);
        chk("arst_err", err_underflow, 1'b0);
        model_reset();
        wr_pct = 0;
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        m_ready = 1'b1;
        rd_seen = 0;
        run(5);
        chk("post_rst_reads", rd_seen, 0);
        chk("post_rst_valid", m_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_rd_drain.md
# fifo_rd_drain

Read-side controller for the synchronous FIFO: it drives the FIFO read enable, captures the registered read data one cycle later, and presents it downstream as a valid/ready stream through a 2-entry skid buffer. It sits between the FIFO read port and any consumer. It never underflows the FIFO, sustains one word per cycle, and flags any underflow the FIFO reports.

## Interface
- FIFO_WIDTH, 16, data word width
- CNT_W, 16, width of the words-delivered counter
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  drain enable; 1 = issue reads, 0 = stop issuing and drain in-flight word
- fifo_rd_en  out  1  FIFO read enable
- fifo_data_out  in  FIFO_WIDTH  FIFO read data, valid the cycle after an accepted read
- fifo_empty  in  1  FIFO empty flag
- fifo_underflow  in  1  FIFO underflow flag
- m_data  out  FIFO_WIDTH  downstream data (skid head)
- m_valid  out  1  downstream valid
- m_ready  in  1  downstream ready
- busy  out  1  1 when state != IDLE or skid occupancy != 0
- rd_count  out  CNT_W  words delivered downstream (m_valid && m_ready)
- err_underflow  out  1  sticky underflow error
- clr_err  in  1  synchronous clear of err_underflow

## Operation
- States: IDLE, ACTIVE, DRAIN.
  - IDLE -> ACTIVE when en=1.
  - ACTIVE -> DRAIN when en=0.
  - DRAIN -> IDLE when inflight=0.
  - DRAIN -> ACTIVE when en=1 again.
- inflight: 1-bit register, set in the cycle after fifo_rd_en=1; that cycle captures fifo_data_out into the skid buffer.
- occ: skid occupancy, 0..2.
- pop = m_valid && m_ready.
- Read issue (combinational): fifo_rd_en = (state==ACTIVE) && en && !fifo_empty && (occ + inflight - pop) < 2. This guarantees the skid never overflows.
- Skid update per cycle: occ_next = occ + inflight - pop. Push and pop in the same cycle are legal. FIFO order is preserved, with the head at m_data.
- m_valid = (occ != 0). m_data holds the head entry and is stable while m_valid && !m_ready.
- rd_count increments on each pop and wraps modulo 2^CNT_W.
- err_underflow is set when fifo_underflow=1 in any cycle, or when fifo_rd_en=1 && fifo_empty=1 (a design-bug guard). clr_err clears it; if set and clear occur in the same cycle, set wins.
- en deassertion never discards data. Words already in the skid remain presentable in IDLE.

## Timing
- Reset values: fifo_rd_en=0, m_valid=0, m_data=0, busy=0, rd_count=0, err_underflow=0, state=IDLE, occ=0, inflight=0.
- Read latency: fifo_rd_en at cycle t -> word captured at edge t+1 -> m_valid at t+1 if the skid was empty. Empty-skid-to-output latency is 1 cycle after the read.
- Throughput: with m_ready held at 1 and the FIFO non-empty, fifo_rd_en stays at 1 every cycle and m_valid stays at 1 from t+1 on.
- Backpressure: m_ready=0 for N cycles -> at most 2 words buffered, and fifo_rd_en drops within 1 cycle of occ+inflight reaching 2.
- fifo_empty is sampled combinationally in the issue cycle. A read in cycle t on the last word sees fifo_empty=1 at t+1 with no extra read.
- Asynchronous reset mid-transfer drops any in-flight and buffered words and clears all state. The FIFO is reset by the same rst_n.

## Structure
- Shared package fifo_pkg holds:
  - FIFO_WIDTH and FIFO_DEPTH defaults
  - rd_state_e enum {IDLE, ACTIVE, DRAIN}
  - SKID_DEPTH=2 constant
- Sub-module fifo_rd_skid is the 2-entry ordered buffer, with inputs push/pop/din and outputs dout/occ. The top holds the FSM, the issue logic, the counter and the error flag.
- Both modules connect to the FIFO through the existing FIFO interface signals (rd_en, data_out, empty, underflow).

## Test plan
- Reset then en=1 with FIFO preloaded 0x0001..0x0008 and m_ready=1: rd_en high 8 consecutive cycles, m_data 0x0001..0x0008 on consecutive cycles, rd_count=8, no rd_en while empty.
- m_ready=0 for 10 cycles with 8 words in the FIFO: exactly 2 reads issued, m_valid=1 holding 0x0001 stable; release m_ready -> remaining words in order, none lost or duplicated.
- Random m_ready (50%) streaming 1000 words: output sequence matches the write sequence, occ ≤ 2 always, err_underflow=0.
- en dropped one cycle after a read: state DRAIN, in-flight word delivered, then IDLE; busy=0 after the skid empties; no further rd_en.
- Force fifo_underflow=1 for 1 cycle: err_underflow=1 and sticky; clr_err=1 -> 0; clr_err coincident with a new underflow -> stays 1.
- Assert rst_n=0 mid-stream with occ=2: all outputs return to reset values asynchronously; after release with the FIFO empty, m_valid=0 and rd_en=0.
